// File: rtl/bn_pkg.sv
// bn_pkg: shared types and constants for the Batch_Norm channel sequencer.
//   bn_state_e     : sequencer FSM state encoding
//   FP_ONE/FP_ZERO : FP32 reset values for the scale/shift coefficients
//   BN_LATENCY_DEF : default FP_Mul + FP_Adder register depth
package bn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bn_state_e;

  localparam logic [31:0] FP_ONE         = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO        = 32'h0000_0000;
  localparam int          BN_LATENCY_DEF = 2;

endpackage

// File: rtl/bn_channel_sequencer_if.sv
// bn_channel_sequencer_if: bundles the configuration, input stream,
// datapath and output stream signals of the sequencer.
//   master : environment side (drives config, input beats, datapath result)
//   slave  : sequencer side
interface bn_channel_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_W       = 6,
  parameter int PIX_W      = 16
);
  logic                  Cfg_We;
  logic                  Cfg_Sel;
  logic [CH_W-1:0]       Cfg_Addr;
  logic [DATA_WIDTH-1:0] Cfg_Data;
  logic [CH_W-1:0]       Num_Ch;
  logic [PIX_W-1:0]      Pix_Per_Ch;
  logic                  Start;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] In_Data;
  logic                  In_Valid;
  logic                  In_Ready;
  logic [DATA_WIDTH-1:0] BN_Data_A;
  logic [DATA_WIDTH-1:0] BN_Data_B;
  logic [DATA_WIDTH-1:0] BN_Data_In;
  logic                  BN_Valid_In;
  logic [DATA_WIDTH-1:0] BN_Data_Out;
  logic [DATA_WIDTH-1:0] Out_Data;
  logic                  Out_Valid;
  logic [CH_W-1:0]       Out_Ch;
  logic                  Out_Last;

  modport master (
    output Cfg_We, Cfg_Sel, Cfg_Addr, Cfg_Data, Num_Ch, Pix_Per_Ch, Start,
           In_Data, In_Valid, BN_Data_Out,
    input  Busy, Done, In_Ready, BN_Data_A, BN_Data_B, BN_Data_In,
           BN_Valid_In, Out_Data, Out_Valid, Out_Ch, Out_Last
  );

  modport slave (
    input  Cfg_We, Cfg_Sel, Cfg_Addr, Cfg_Data, Num_Ch, Pix_Per_Ch, Start,
           In_Data, In_Valid, BN_Data_Out,
    output Busy, Done, In_Ready, BN_Data_A, BN_Data_B, BN_Data_In,
           BN_Valid_In, Out_Data, Out_Valid, Out_Ch, Out_Last
  );
endinterface

// File: rtl/bn_coef_regfile.sv
// bn_coef_regfile: per-channel FP32 scale (A) and shift (B) storage.
//   clk, rst    : clock, synchronous active-low reset (A=1.0, B=0.0)
//   i_we, i_sel : write strobe, 0 writes A / 1 writes B
//   i_waddr     : write channel (out-of-range addresses are dropped)
//   i_wdata     : FP32 coefficient
//   i_raddr     : combinational read channel
//   o_a, o_b    : coefficients of channel i_raddr
module bn_coef_regfile
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CH     = 64,
  parameter int CH_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_sel,
  input  logic [CH_W-1:0]       i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [CH_W-1:0]       i_raddr,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b
);
  logic [DATA_WIDTH-1:0] r_a [MAX_CH];
  logic [DATA_WIDTH-1:0] r_b [MAX_CH];

  // Coefficient storage: identity transform after reset, single write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_CH; i++) begin
        r_a[i] <= DATA_WIDTH'(FP_ONE);
        r_b[i] <= DATA_WIDTH'(FP_ZERO);
      end
    end else if (i_we && (int'(i_waddr) < MAX_CH)) begin
      if (i_sel) begin
        r_b[i_waddr] <= i_wdata;
      end else begin
        r_a[i_waddr] <= i_wdata;
      end
    end
  end

  assign o_a = (int'(i_raddr) < MAX_CH) ? r_a[i_raddr] : DATA_WIDTH'(FP_ONE);
  assign o_b = (int'(i_raddr) < MAX_CH) ? r_b[i_raddr] : DATA_WIDTH'(FP_ZERO);
endmodule

// File: rtl/bn_channel_sequencer.sv
// bn_channel_sequencer: streams a multi-channel feature map through the
// external Batch_Norm datapath (FP_Mul -> FP_Adder, BN_LATENCY stages).
//   clk, rst : clock, synchronous active-low reset (aborts any frame)
//   bus      : slave side of bn_channel_sequencer_if
//              config   Cfg_*, Num_Ch, Pix_Per_Ch, Start -> Busy, Done
//              input    In_Data/In_Valid -> In_Ready
//              datapath BN_Data_A/B/In, BN_Valid_In <- BN_Data_Out
//              output   Out_Data, Out_Valid, Out_Ch, Out_Last
module bn_channel_sequencer
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CH     = 64,
  parameter int CH_W       = 6,
  parameter int PIX_W      = 16,
  parameter int BN_LATENCY = BN_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  bn_channel_sequencer_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic            last;
  } tag_t;

  bn_state_e             r_state;
  logic [CH_W-1:0]       r_ch;
  logic [CH_W-1:0]       r_ch_lim;
  logic [PIX_W-1:0]      r_pix;
  logic [PIX_W-1:0]      r_pix_lim;
  logic [7:0]            r_drain_cnt;
  logic [DATA_WIDTH-1:0] r_hold_a;
  logic [DATA_WIDTH-1:0] r_hold_b;
  logic [DATA_WIDTH-1:0] r_hold_in;
  tag_t                  r_tag [BN_LATENCY];

  logic                  w_fire;
  logic                  w_pix_wrap;
  logic                  w_last;
  logic                  w_cfg_we;
  logic [DATA_WIDTH-1:0] w_coef_a;
  logic [DATA_WIDTH-1:0] w_coef_b;

  assign w_fire     = (r_state == RUN) && bus.In_Valid;
  assign w_pix_wrap = (r_pix == r_pix_lim);
  assign w_last     = w_fire && w_pix_wrap && (r_ch == r_ch_lim);
  // Coefficients are frozen for the whole frame, including drain.
  assign w_cfg_we   = bus.Cfg_We && (r_state == IDLE);

  bn_coef_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_CH     (MAX_CH),
    .CH_W       (CH_W)
  ) u_coef (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cfg_we),
    .i_sel   (bus.Cfg_Sel),
    .i_waddr (bus.Cfg_Addr),
    .i_wdata (bus.Cfg_Data),
    .i_raddr (r_ch),
    .o_a     (w_coef_a),
    .o_b     (w_coef_b)
  );

  // Frame FSM with channel/pixel counters and post-frame drain counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ch        <= '0;
      r_ch_lim    <= '0;
      r_pix       <= '0;
      r_pix_lim   <= '0;
      r_drain_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_ch_lim  <= bus.Num_Ch;
            r_pix_lim <= bus.Pix_Per_Ch;
            r_ch      <= '0;
            r_pix     <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_fire) begin
            if (w_pix_wrap) begin
              r_pix <= '0;
              if (r_ch == r_ch_lim) begin
                r_ch        <= '0;
                r_drain_cnt <= 8'd0;
                r_state     <= DRAIN;
              end else begin
                r_ch <= r_ch + CH_W'(1);
              end
            end else begin
              r_pix <= r_pix + PIX_W'(1);
            end
          end
        end
        // Wait until the last beat has left the datapath.
        DRAIN: begin
          if (r_drain_cnt == 8'(BN_LATENCY - 1)) begin
            r_state <= DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Datapath operands keep their last issued values between beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_a  <= '0;
      r_hold_b  <= '0;
      r_hold_in <= '0;
    end else if (w_fire) begin
      r_hold_a  <= w_coef_a;
      r_hold_b  <= w_coef_b;
      r_hold_in <= bus.In_Data;
    end
  end

  // Tag pipe mirrors the datapath depth so tags line up with BN_Data_Out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BN_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_fire, ch: (w_fire ? r_ch : '0), last: w_last};
      for (int i = 1; i < BN_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign bus.Busy        = (r_state != IDLE);
  assign bus.Done        = (r_state == DONE);
  assign bus.In_Ready    = (r_state == RUN);
  assign bus.BN_Valid_In = w_fire;
  assign bus.BN_Data_In  = w_fire ? bus.In_Data : r_hold_in;
  assign bus.BN_Data_A   = w_fire ? w_coef_a : r_hold_a;
  assign bus.BN_Data_B   = w_fire ? w_coef_b : r_hold_b;
  assign bus.Out_Valid   = r_tag[BN_LATENCY-1].valid;
  assign bus.Out_Ch      = r_tag[BN_LATENCY-1].ch;
  assign bus.Out_Last    = r_tag[BN_LATENCY-1].last;
  assign bus.Out_Data    = r_tag[BN_LATENCY-1].valid ? bus.BN_Data_Out
                                                     : DATA_WIDTH'(FP_ZERO);
endmodule
